// File: rtl/aexm_ifetch.sv
// Instruction fetch stage: icache request/ack handshake, 2-entry prefetch queue, decode register.
// Define AEXM_IFETCH_PERF_EN to add saturating fetch/stall performance counters.
module aexm_ifetch #(
  parameter int          QAW  = 1,
  parameter logic [31:0] NOPW = 32'h80000000
) (
  input  logic        gclk,
  input  logic        grst_n,
  input  logic        x_en,
  input  logic        d_en,
  input  logic [31:0] aexm_icache_precycle_addr,
  input  logic        dSKIP,
  output logic        icache_req,
  output logic [29:0] icache_addr,
  input  logic        icache_ack,
  input  logic [31:0] icache_dat,
  output logic [31:0] xIREG,
  output logic [5:0]  rOPC,
  output logic [4:0]  rRD,
  output logic [4:0]  rRA,
  output logic [4:0]  rRB,
  output logic [31:0] rSIMM,
  output logic        fetch_stall
`ifdef AEXM_IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam int QD = 1 << QAW;
  localparam logic [QAW:0] CNT_FULL = {1'b1, {QAW{1'b0}}};
  localparam logic [5:0] OPC_IMM = 6'o54;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [29:0]    addr_q, addr_d, pend_addr_q, pend_addr_d;
  logic           pend_valid_q, pend_valid_d;
  logic           drop_q, drop_d;
  logic [31:0]    q_mem_q [QD];
  logic [QAW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [QAW:0]   cnt_q, cnt_d;
  logic [31:0]    xireg_q, xireg_d, rsimm_q, rsimm_d;
  logic           stall_q, stall_d, imm_q, imm_d;
  logic [15:0]    imm_hi_q, imm_hi_d;

  logic        ack_in_req, push_acc, load, pop, bypass, enq, f_real;
  logic        have_addr, issue;
  logic [31:0] f_word;
  logic [29:0] want_addr;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^aexm_icache_precycle_addr[1:0];

  always_comb begin
    ack_in_req = (state_q == REQ) && icache_ack;
    // A dropped response (stale after a squash) never reaches the queue.
    push_acc   = ack_in_req && !drop_q && !dSKIP;
    load       = d_en && !dSKIP;
    pop        = load && (cnt_q != '0);
    bypass     = load && (cnt_q == '0) && push_acc;
    enq        = push_acc && !bypass;
    f_real     = pop || bypass;
    f_word     = pop ? q_mem_q[rd_ptr_q] : (bypass ? icache_dat : NOPW);

    cnt_d    = dSKIP ? '0 : cnt_q + (QAW+1)'(enq) - (QAW+1)'(pop);
    rd_ptr_d = dSKIP ? '0 : rd_ptr_q + QAW'(pop);
    wr_ptr_d = dSKIP ? '0 : wr_ptr_q + QAW'(enq);

    xireg_d  = xireg_q;
    rsimm_d  = rsimm_q;
    stall_d  = 1'b0;
    imm_d    = imm_q;
    imm_hi_d = imm_hi_q;
    if (dSKIP) begin
      xireg_d = NOPW;
      rsimm_d = '0;
      imm_d   = 1'b0;
    end else if (load) begin
      xireg_d = f_word;
      stall_d = !f_real;
      rsimm_d = imm_q ? {imm_hi_q, f_word[15:0]} : {{16{f_word[15]}}, f_word[15:0]};
      // Bubbles leave the IMM prefix untouched so it survives stalls.
      if (f_real) begin
        imm_d    = (f_word[31:26] == OPC_IMM);
        imm_hi_d = f_word[15:0];
      end
    end

    have_addr = x_en || (pend_valid_q && !dSKIP);
    want_addr = x_en ? aexm_icache_precycle_addr[31:2] : pend_addr_q;
    issue     = ((state_q == IDLE) || ack_in_req) && have_addr && (cnt_d != CNT_FULL);

    state_d      = state_q;
    addr_d       = addr_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    drop_d       = drop_q;
    if (ack_in_req) state_d = IDLE;
    if (ack_in_req) drop_d = 1'b0;
    else if (dSKIP && (state_q == REQ)) drop_d = 1'b1;
    if (dSKIP) pend_valid_d = 1'b0;
    if (issue) begin
      state_d      = REQ;
      addr_d       = want_addr;
      pend_valid_d = 1'b0;
    end else if (x_en) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = aexm_icache_precycle_addr[31:2];
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      pend_addr_q  <= '0;
      pend_valid_q <= 1'b0;
      drop_q       <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      xireg_q      <= NOPW;
      rsimm_q      <= '0;
      stall_q      <= 1'b0;
      imm_q        <= 1'b0;
      imm_hi_q     <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      pend_addr_q  <= pend_addr_d;
      pend_valid_q <= pend_valid_d;
      drop_q       <= drop_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      xireg_q      <= xireg_d;
      rsimm_q      <= rsimm_d;
      stall_q      <= stall_d;
      imm_q        <= imm_d;
      imm_hi_q     <= imm_hi_d;
    end
  end

  always_ff @(posedge gclk) begin
    if (enq) q_mem_q[wr_ptr_q] <= icache_dat;
  end

  assign icache_req  = (state_q == REQ);
  assign icache_addr = addr_q;
  assign xIREG       = xireg_q;
  assign rOPC        = xireg_q[31:26];
  assign rRD         = xireg_q[25:21];
  assign rRA         = xireg_q[20:16];
  assign rRB         = xireg_q[15:11];
  assign rSIMM       = rsimm_q;
  assign fetch_stall = stall_q;

`ifdef AEXM_IFETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (push_acc && (perf_fetch_q != '1)) perf_fetch_d = perf_fetch_q + 32'd1;
    if (stall_q && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif
endmodule

// File: doc/aexm_ifetch.md
Name: aexm_ifetch

Overview:
Instruction fetch stage directly downstream of the branch/PC unit. It takes the precycle fetch address the branch unit produces and runs the request/acknowledge handshake to the instruction cache. Returned words are buffered in a 2-entry prefetch queue and presented to decode as xIREG plus pre-split fields and a resolved 32-bit immediate. It squashes in-flight fetches when the branch unit signals a skip/redirect.

Parameters:
QAW, 1, log2 of prefetch queue depth (depth 2; only 1 supported).
NOPW, 32'h80000000, bubble instruction word (or r0,r0,r0) injected when the queue is empty.

Ports:
gclk  in  1  system clock, all state on rising edge.
grst_n  in  1  asynchronous active-low reset.
x_en  in  1  pipeline advance; the precycle address is valid this cycle.
d_en  in  1  decode consumes one instruction this cycle.
aexm_icache_precycle_addr  in  32  next fetch address from the branch unit; bits [1:0] ignored.
dSKIP  in  1  squash: flush the queue and drop any outstanding response.
icache_req  out  1  fetch request, held until ack.
icache_addr  out  30  word address of the request.
icache_ack  in  1  data valid and request retired.
icache_dat  in  32  instruction word, valid with ack.
xIREG  out  32  current decoded instruction.
rOPC  out  6  xIREG[31:26].
rRD  out  5  xIREG[25:21].
rRA  out  5  xIREG[20:16].
rRB  out  5  xIREG[15:11].
rSIMM  out  32  resolved immediate.
fetch_stall  out  1  queue empty while d_en is high (bubble issued).

Behaviour:
- Reset (async, grst_n=0): icache_req=0; icache_addr=0; queue empty; xIREG=NOPW; rOPC/rRD/rRA/rRB take NOPW fields; rSIMM=0; fetch_stall=0; IMM-pending flag cleared; drop counter=0.
- Request FSM, states IDLE, REQ:
  - IDLE -> REQ when x_en=1 and the queue is not full (counting the outstanding slot). icache_addr latches aexm_icache_precycle_addr[31:2].
  - In REQ, icache_req=1 and icache_addr is held stable until ack.
  - REQ + ack: if drop counter=0, push {icache_dat} to the queue. Otherwise decrement the drop counter and discard the data. In both cases go back to IDLE, or reissue directly to REQ if x_en=1 in the same cycle.
  - x_en while in REQ: the address is held in a 1-deep pending address register and issued after ack. A second x_en while pending is full overwrites it, so the newest address wins.
- Queue: 2 entries. Push on accepted ack; pop on d_en with the queue non-empty.
  - Simultaneous push and pop on an empty queue: bypass, so xIREG takes icache_dat that cycle-edge.
  - Full queue: no new request is issued. It is never overflowed.
- Decode register: on d_en, xIREG <= queue head, or NOPW with fetch_stall=1 if the queue is empty. Latency from ack to xIREG is 1 cycle minimum (bypass).
- Immediate resolve: on the edge that loads xIREG, with f = loaded word:
  - If the currently held xIREG has opcode 6'o54 (IMM) and was not a bubble, rSIMM <= {held[15:0], f[15:0]}.
  - Otherwise rSIMM <= sign-extended f[15:0].
  - A bubble does not consume a pending IMM. The IMM prefix survives stalls.
- dSKIP (sampled at the edge):
  - Queue cleared and pending address cleared.
  - If in REQ without ack this cycle, drop counter <= 1. If ack arrives in the same cycle as dSKIP, that data is discarded.
  - xIREG <= NOPW and the IMM prefix is cleared.
  - The x_en address in the same cycle is accepted as the new fetch target (redirect wins over squash).
- dSKIP has priority over d_en; d_en has priority over push ordering.

Optional Feature:
AEXM_IFETCH_PERF_EN: when defined, adds two 32-bit saturating counters, perf_fetch_cnt (accepted acks) and perf_stall_cnt (cycles with fetch_stall=1). Both are reset to 0 by grst_n and exposed as output ports perf_fetch_cnt and perf_stall_cnt. When undefined, neither the ports nor the logic exist.

Test Plan:
- Reset with grst_n=0 mid-REQ -> icache_req=0 and xIREG=32'h80000000 immediately (async); after release, no ghost push occurs from a late ack.
- x_en with addr 32'h00000104, ack after 3 cycles with data 32'hA0230005, d_en held high -> icache_addr=30'h41; xIREG=32'hA0230005 one edge after ack; rSIMM=32'h00000005; fetch_stall=1 during the wait cycles.
- IMM sequence: data 32'hB0001234 then 32'h3021FFF0 -> rSIMM=32'h1234FFF0 for the second. Without the IMM, the same word gives rSIMM=32'hFFFFFFF0. Insert a 2-cycle stall between them and the prefix must still apply.
- dSKIP while REQ outstanding, x_en addr 32'h00000200 the same cycle -> the old ack data is discarded; the next request issues icache_addr=30'h80; xIREG=NOP until new data arrives.
- d_en low for 4 cycles with back-to-back acks -> queue fills at 2 and icache_req stays 0. On the first d_en, entries pop in order and a new request issues.
- With AEXM_IFETCH_PERF_EN: 5 fetches and 3 stall cycles -> perf_fetch_cnt=5, perf_stall_cnt=3.
